// File: rtl/multicase_filter_pkg.sv
// Shared constants and types for the two-case first-order low-pass filter.
package multicase_filter_pkg;

  localparam int unsigned COEF_FRAC_BITS = 17;

  // Unsigned Q1.17 filter coefficient.
  typedef logic [17:0] coef_t;

  // Case-0 default: coefficient of zero freezes the state.
  localparam coef_t ALPHA_HOLD  = 18'd0;
  // 1 - e^(-0.1) in Q1.17, i.e. a time constant of 10 cycles.
  localparam coef_t ALPHA_TAU10 = 18'd12473;

endpackage

// File: rtl/fixed_align.sv
// Fixed-point width/exponent converter.
// Left-shifts when the input exponent is larger, floor-shifts right when it
// is smaller, then fits the result into OUT_W bits.
// MULTICASE_FILTER_SAT_EN defined: clamp to +/-(2^(OUT_W-1)-1).
// Otherwise: keep the low OUT_W bits (two's-complement wrap).
module fixed_align #(
  parameter int IN_W  = 18,
  parameter int IN_E  = -16,
  parameter int OUT_W = 18,
  parameter int OUT_E = -16
) (
  input  logic signed [IN_W-1:0]  din,
  output logic signed [OUT_W-1:0] dout
);

  localparam int SH  = IN_E - OUT_E;
  localparam int LSH = (SH > 0) ? SH : 0;
  localparam int RSH = (SH < 0) ? -SH : 0;
  // One guard bit above the larger of the shifted input and the output.
  localparam int WW  = (((IN_W + LSH) > OUT_W) ? (IN_W + LSH) : OUT_W) + 1;

  localparam logic signed [WW-1:0] MAXV = WW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
  localparam logic signed [WW-1:0] MINV = -MAXV;

  logic signed [WW-1:0] ext;
  logic signed [WW-1:0] shifted;
  logic                 unused_hi;

  assign ext       = WW'(din);
  assign shifted   = (ext <<< LSH) >>> RSH;
  assign unused_hi = ^shifted[WW-1:OUT_W];

  // Fit the aligned value into the output width.
  always_comb begin
    dout = shifted[OUT_W-1:0];
`ifdef MULTICASE_FILTER_SAT_EN
    if (shifted > MAXV) begin
      dout = MAXV[OUT_W-1:0];
    end else if (shifted < MINV) begin
      dout = MINV[OUT_W-1:0];
    end
`endif
  end

endmodule

// File: rtl/multicase_filter.sv
// Two-case first-order low-pass filter: each cycle
//   v_out <= v_out + floor((align(v_in) - v_out) * alpha_sel / 2^17)
// with alpha_sel chosen by ctrl. Saturation of the aligned input and of the
// updated state is enabled by MULTICASE_FILTER_SAT_EN (wrap otherwise).
module multicase_filter
  import multicase_filter_pkg::*;
#(
  parameter int    IN_WIDTH  = 18,
  parameter int    IN_EXP    = -16,
  parameter int    OUT_WIDTH = 18,
  parameter int    OUT_EXP   = -16,
  parameter coef_t ALPHA0    = ALPHA_HOLD,
  parameter coef_t ALPHA1    = ALPHA_TAU10
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic signed [IN_WIDTH-1:0]  v_in,
  input  logic                        ctrl,
  output logic signed [OUT_WIDTH-1:0] v_out
);

  localparam int DW = OUT_WIDTH + 1;   // difference
  localparam int PW = OUT_WIDTH + 19;  // product
  localparam int SW = OUT_WIDTH + 2;   // sum before clamp

  logic signed [OUT_WIDTH-1:0] vin_a;
  coef_t                       alpha_sel;
  logic signed [DW-1:0]        diff;
  logic signed [PW-1:0]        prod;
  logic signed [PW-1:0]        scaled;
  logic signed [SW-1:0]        sum_w;
  logic signed [OUT_WIDTH-1:0] next_v;
  logic                        unused_scaled;

  fixed_align #(
    .IN_W (IN_WIDTH),
    .IN_E (IN_EXP),
    .OUT_W(OUT_WIDTH),
    .OUT_E(OUT_EXP)
  ) u_in_align (
    .din (v_in),
    .dout(vin_a)
  );

  // Coefficient select, difference, product and floor-scaled increment.
  always_comb begin
    alpha_sel = ctrl ? ALPHA1 : ALPHA0;
    diff      = DW'(vin_a) - DW'(v_out);
    prod      = PW'(diff) * PW'($signed({1'b0, alpha_sel}));
    scaled    = prod >>> COEF_FRAC_BITS;
    sum_w     = SW'(v_out) + scaled[SW-1:0];
  end

  // Bits above SW are sign copies once the increment is bounded by |diff|.
  assign unused_scaled = ^scaled[PW-1:SW];

  fixed_align #(
    .IN_W (SW),
    .IN_E (OUT_EXP),
    .OUT_W(OUT_WIDTH),
    .OUT_E(OUT_EXP)
  ) u_out_clamp (
    .din (sum_w),
    .dout(next_v)
  );

  // Filter state register with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      v_out <= '0;
    end else begin
      v_out <= next_v;
    end
  end

endmodule

// File: tb/tb_multicase_filter.sv
// Self-checking bench for multicase_filter: vector table, hand-written
// sequences, and randomized stimulus against an arithmetic reference model.
module tb_multicase_filter;

  logic               clk = 1'b0;
  logic               rst;
  logic signed [17:0] vin;
  logic               ctrl;
  logic signed [17:0] vout;
  logic signed [17:0] vin2;
  logic               ctrl2;
  logic signed [17:0] vout2;

  int total = 0;
  int bad   = 0;

  longint ma = 0;
  longint mb = 0;

  always #5 clk = ~clk;

  multicase_filter u_dut (
    .clk  (clk),
    .rst  (rst),
    .v_in (vin),
    .ctrl (ctrl),
    .v_out(vout)
  );

  multicase_filter #(.ALPHA1(131072)) u_dut_unity (
    .clk  (clk),
    .rst  (rst),
    .v_in (vin2),
    .ctrl (ctrl2),
    .v_out(vout2)
  );

  function automatic longint fit18(longint x);
`ifdef MULTICASE_FILTER_SAT_EN
    if (x > 131071) return 131071;
    if (x < -131071) return -131071;
    return x;
`else
    return ((x + 131072) & 262143) - 131072;
`endif
  endfunction

  // Real-valued rule in integer form: move by floor(alpha * error) per cycle.
  function automatic longint mstep(longint cur, longint x, longint alpha);
    longint xa;
    xa = fit18(x);
    return fit18(cur + (((xa - cur) * alpha) >>> 17));
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Advance one clock, updating both models, and compare both outputs.
  task automatic step();
    if (rst) begin
      ma = 0;
      mb = 0;
    end else begin
      ma = mstep(ma, longint'(vin), ctrl ? 12473 : 0);
      mb = mstep(mb, longint'(vin2), ctrl2 ? 131072 : 0);
    end
    @(posedge clk);
    #1;
    chk("model_a", longint'(vout), ma);
    chk("model_b", longint'(vout2), mb);
  endtask

  typedef struct {
    logic   r;
    longint x;
    logic   c;
    longint e;
  } vec_t;

  vec_t   vecs[$];
  longint prev;
  longint held;

  initial begin
    rst = 1'b1; vin = 18'sd0; ctrl = 1'b0; vin2 = 18'sd0; ctrl2 = 1'b0;

    // Reset, first steps, hold, mid-run reset and a negative input.
    vecs.push_back('{1'b1, 65536, 1'b1, 0});
    vecs.push_back('{1'b1, 65536, 1'b1, 0});
    vecs.push_back('{1'b1, 65536, 1'b1, 0});
    vecs.push_back('{1'b0, 65536, 1'b1, 6236});
    vecs.push_back('{1'b0, 65536, 1'b1, 11879});
    vecs.push_back('{1'b0, 65536, 1'b0, 11879});
    vecs.push_back('{1'b0, -65536, 1'b0, 11879});
    vecs.push_back('{1'b0, 65536, 1'b1, 16985});
    vecs.push_back('{1'b1, 65536, 1'b1, 0});
    vecs.push_back('{1'b0, 65536, 1'b1, 6236});
    vecs.push_back('{1'b0, -65536, 1'b1, -594});
    foreach (vecs[i]) begin
      rst  = vecs[i].r;
      vin  = 18'(vecs[i].x);
      ctrl = vecs[i].c;
      step();
      chk($sformatf("vec%0d", i), longint'(vout), vecs[i].e);
    end

    // Hold: five charging cycles, then ctrl low must freeze the output.
    rst = 1'b1; step();
    rst = 1'b0; vin = 18'sd65536; ctrl = 1'b1;
    for (int unsigned i = 0; i < 5; i++) step();
    held = longint'(vout);
    ctrl = 1'b0;
    for (int unsigned i = 0; i < 16; i++) begin
      vin = 18'($urandom);
      step();
      chk("hold", longint'(vout), held);
    end

    // Convergence with ctrl following bit 4 of a cycle counter.
    rst = 1'b1; step();
    rst = 1'b0; vin = 18'sd65536;
    prev = 0;
    for (int unsigned i = 0; i < 400; i++) begin
      ctrl = i[4];
      step();
      if (longint'(vout) < prev) chk("monotonic", longint'(vout), prev);
      prev = longint'(vout);
    end
    chk("converge_lo", (longint'(vout) >= 65526) ? 1 : 0, 1);
    chk("converge_hi", (longint'(vout) <= 65536) ? 1 : 0, 1);

    // Unity coefficient: full-scale positive, then most-negative input.
    rst = 1'b1; step();
    rst = 1'b0; ctrl2 = 1'b1; vin2 = 18'sd131071;
    step();
    chk("unity_pos", longint'(vout2), 131071);
    vin2 = -18'sd131072;
    step();
`ifdef MULTICASE_FILTER_SAT_EN
    chk("unity_neg", longint'(vout2), -131071);
`else
    chk("unity_neg", longint'(vout2), -131072);
`endif

    // Mid-run reset near 40000, then the first step repeats.
    rst = 1'b1; step();
    rst = 1'b0; vin = 18'sd65536; ctrl = 1'b1;
    while (longint'(vout) < 40000 && total < 100000) step();
    rst = 1'b1; step();
    chk("midrun_rst", longint'(vout), 0);
    rst = 1'b0; step();
    chk("after_rst", longint'(vout), 6236);

    // Randomized inputs, ctrl and occasional reset against the model.
    for (int unsigned i = 0; i < 300; i++) begin
      rst   = ($urandom_range(0, 31) == 0);
      vin   = 18'($urandom);
      ctrl  = $urandom_range(0, 1) == 1;
      vin2  = 18'($urandom);
      ctrl2 = $urandom_range(0, 1) == 1;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
